// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase, lamp pattern and error code definitions
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_SYNC = 3'd0,
    PH_R    = 3'd1,
    PH_RA   = 3'd2,
    PH_G    = 3'd3,
    PH_A    = 3'd4
  } phase_t;

  typedef enum logic [1:0] {
    ERR_PATTERN = 2'd0,
    ERR_ORDER   = 2'd1,
    ERR_SHORT   = 2'd2,
    ERR_LONG    = 2'd3
  } err_code_t;

  // Lamp patterns as {red, amber, green}
  localparam logic [2:0] LAMP_R  = 3'b100;
  localparam logic [2:0] LAMP_RA = 3'b110;
  localparam logic [2:0] LAMP_G  = 3'b001;
  localparam logic [2:0] LAMP_A  = 3'b010;

  // Next phase in the R -> R+A -> G -> A -> R sequence
  function automatic phase_t successor(input phase_t p);
    phase_t s;
    case (p)
      PH_R:    s = PH_RA;
      PH_RA:   s = PH_G;
      PH_G:    s = PH_A;
      PH_A:    s = PH_R;
      default: s = PH_SYNC;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tl_pattern_decode.sv
// rtl/tl_pattern_decode.sv - combinational lamp pattern to phase decoder
module tl_pattern_decode
  import traffic_pkg::*;
(
  input  logic   red,
  input  logic   amber,
  input  logic   green,
  output phase_t phase,
  output logic   illegal
);

  // Map the four legal lamp patterns to phases; anything else is illegal
  always_comb begin
    phase   = PH_SYNC;
    illegal = 1'b0;
    case ({red, amber, green})
      LAMP_R:  phase = PH_R;
      LAMP_RA: phase = PH_RA;
      LAMP_G:  phase = PH_G;
      LAMP_A:  phase = PH_A;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - sequence and dwell checker for traffic light lamps
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic             err_sticky,
  output logic [CNT_W-1:0] seq_count
);

  phase_t           obs_phase;
  logic             obs_illegal;

  phase_t           phase_q,   phase_n;
  logic [CNT_W-1:0] dwell_q,   dwell_n;
  logic             first_q,   first_n;
  logic             long_q,    long_n;
  logic             err_v_q,   err_v_n;
  err_code_t        err_c_q,   err_c_n;
  logic             sticky_q,  sticky_n;
  logic [CNT_W-1:0] seq_q,     seq_n;

  tl_pattern_decode u_decode (
    .red     (red),
    .amber   (amber),
    .green   (green),
    .phase   (obs_phase),
    .illegal (obs_illegal)
  );

  // State register: tracked phase, dwell history and registered verdicts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_SYNC;
      dwell_q  <= '0;
      first_q  <= 1'b1;
      long_q   <= 1'b0;
      err_v_q  <= 1'b0;
      err_c_q  <= ERR_PATTERN;
      sticky_q <= 1'b0;
      seq_q    <= '0;
    end else begin
      phase_q  <= phase_n;
      dwell_q  <= dwell_n;
      first_q  <= first_n;
      long_q   <= long_n;
      err_v_q  <= err_v_n;
      err_c_q  <= err_c_n;
      sticky_q <= sticky_n;
      seq_q    <= seq_n;
    end
  end

  // Judge the sampled lamps against the tracked phase; one error at most per cycle
  always_comb begin
    phase_n = phase_q;
    dwell_n = dwell_q;
    first_n = first_q;
    long_n  = long_q;
    seq_n   = seq_q;
    err_v_n = 1'b0;
    err_c_n = err_c_q;

    if (phase_q == PH_SYNC) begin
      if (obs_illegal) begin
        err_v_n = 1'b1;
        err_c_n = ERR_PATTERN;
      end else begin
        phase_n = obs_phase;
        dwell_n = CNT_W'(1);
        first_n = 1'b1;
        long_n  = 1'b0;
      end
    end else if (obs_illegal) begin
      err_v_n = 1'b1;
      err_c_n = ERR_PATTERN;
      phase_n = PH_SYNC;
      dwell_n = '0;
    end else if (obs_phase == phase_q) begin
      // Holding: LONG fires once, on the cycle dwell would pass MAX_DWELL
      if (dwell_q == CNT_W'(MAX_DWELL) && !long_q) begin
        err_v_n = 1'b1;
        err_c_n = ERR_LONG;
        long_n  = 1'b1;
      end
      if (dwell_q != '1) dwell_n = dwell_q + CNT_W'(1);
    end else if (obs_phase != successor(phase_q)) begin
      err_v_n = 1'b1;
      err_c_n = ERR_ORDER;
      phase_n = obs_phase;
      dwell_n = CNT_W'(1);
      first_n = 1'b1;
      long_n  = 1'b0;
    end else begin
      // Legal step; a short dwell is flagged but the step is still taken
      if (dwell_q < CNT_W'(MIN_DWELL) && !first_q) begin
        err_v_n = 1'b1;
        err_c_n = ERR_SHORT;
      end
      if (phase_q == PH_A) seq_n = seq_q + CNT_W'(1);
      phase_n = obs_phase;
      dwell_n = CNT_W'(1);
      first_n = 1'b0;
      long_n  = 1'b0;
    end

    sticky_n = err_v_n | (sticky_q & ~clr_err);
  end

  assign phase      = phase_q;
  assign err_valid  = err_v_q;
  assign err_code   = err_c_q;
  assign err_sticky = sticky_q;
  assign seq_count  = seq_q;

endmodule
